// File: rtl/dac_wave_buffer_if.sv
// Valid/ready stream link carrying one wide DAC sample word per beat.
interface dac_wave_buffer_if #(
   parameter int DATA_W = 256
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dac_wave_buffer.sv
// Per-channel waveform store: loads sample words while selected, then plays them
// to the DAC stream on a trigger rising edge, once or looping.
module dac_wave_buffer #(
   parameter int DATA_W = 256,
   parameter int MEM_AW = 10,
   parameter int CNT_W  = 16
) (
   input  logic              pl_clk,
   input  logic              rst,
   input  logic              chan_sel,
   input  logic              clear,
   input  logic              loop_en,
   input  logic              trigger,
   input  logic              stop,
   dac_wave_buffer_if.slave  s_axis,
   dac_wave_buffer_if.master m_axis,
   output logic              busy,
   output logic [MEM_AW:0]   words_loaded,
   output logic [CNT_W-1:0]  pass_count
);

   localparam int DEPTH = 2**MEM_AW;

   typedef enum logic {IDLE, PLAY} state_t;
   state_t state_q, state_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [MEM_AW:0]   wr_ptr;
   logic [MEM_AW-1:0] rd_ptr;
   logic              trig_q;
   logic              ready_en;
   logic              fetch_done;
   logic [CNT_W-1:0]  pass_cnt_q;

   logic              trig_edge, in_ready, wr_en, pop, fetch, start, flush;
   logic [DATA_W-1:0] rd_word_p0;
   logic              last_p0, fin_p0;

   logic [DATA_W-1:0] data_p1, skid_data_p1;
   logic              vld_p1, last_p1, fin_p1;
   logic              skid_vld_p1, skid_last_p1, skid_fin_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign trig_edge = trigger & ~trig_q;
   assign pop       = vld_p1 & m_axis.tready;

   // Stage p0: address the stored word and tag where it sits in the pass
   assign rd_word_p0 = mem[rd_ptr];
   assign last_p0    = ({1'b0, rd_ptr} == (wr_ptr - (MEM_AW+1)'(1)));
   assign fin_p0     = last_p0 & ~loop_en;

   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      in_ready = 1'b0;
      wr_en    = 1'b0;
      start    = 1'b0;
      fetch    = 1'b0;
      flush    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = ready_en & chan_sel & ~clear & ~wr_ptr[MEM_AW];
            wr_en    = s_axis.tvalid & in_ready;
            if (trig_edge && (wr_ptr != '0) && !clear) begin
               state_d = PLAY;
               start   = 1'b1;
            end
         end
         PLAY: begin
            busy = 1'b1;
            if (stop || (pop && fin_p1)) begin
               state_d = IDLE;
               flush   = 1'b1;
            end else begin
               // Fetch ahead whenever the output register and skid are not both full
               fetch = ~fetch_done & ~(vld_p1 & skid_vld_p1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         trig_q     <= 1'b0;
         ready_en   <= 1'b0;
         fetch_done <= 1'b0;
         pass_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         trig_q   <= trigger;
         ready_en <= 1'b1;
         if (state_q == IDLE && clear) begin
            wr_ptr <= '0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + (MEM_AW+1)'(1);
         end
         if (start) begin
            rd_ptr     <= '0;
            fetch_done <= 1'b0;
            pass_cnt_q <= '0;
         end else if (fetch) begin
            rd_ptr <= last_p0 ? '0 : rd_ptr + MEM_AW'(1);
            if (fin_p0) fetch_done <= 1'b1;
         end
         if (state_q == PLAY && !stop && pop && last_p1) begin
            pass_cnt_q <= sat_inc(pass_cnt_q);
         end
      end
   end

   always_ff @(posedge pl_clk) begin
      if (wr_en) mem[wr_ptr[MEM_AW-1:0]] <= s_axis.tdata;
   end

   // Stage p1: output register backed by a one-entry skid buffer
   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         data_p1      <= '0;
         vld_p1       <= 1'b0;
         last_p1      <= 1'b0;
         fin_p1       <= 1'b0;
         skid_data_p1 <= '0;
         skid_vld_p1  <= 1'b0;
         skid_last_p1 <= 1'b0;
         skid_fin_p1  <= 1'b0;
      end else if (flush || state_q != PLAY) begin
         data_p1     <= '0;
         vld_p1      <= 1'b0;
         last_p1     <= 1'b0;
         fin_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
      end else if (!vld_p1 || pop) begin
         if (skid_vld_p1) begin
            data_p1     <= skid_data_p1;
            last_p1     <= skid_last_p1;
            fin_p1      <= skid_fin_p1;
            vld_p1      <= 1'b1;
            skid_vld_p1 <= 1'b0;
         end else if (fetch) begin
            data_p1 <= rd_word_p0;
            last_p1 <= last_p0;
            fin_p1  <= fin_p0;
            vld_p1  <= 1'b1;
         end else begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
         end
      end else if (fetch) begin
         skid_data_p1 <= rd_word_p0;
         skid_last_p1 <= last_p0;
         skid_fin_p1  <= fin_p0;
         skid_vld_p1  <= 1'b1;
      end
   end

   assign s_axis.tready = in_ready;
   assign m_axis.tdata  = data_p1;
   assign m_axis.tvalid = vld_p1;
   assign words_loaded  = wr_ptr;
   assign pass_count    = pass_cnt_q;

endmodule
